// File: rtl/usbdev_pkg.sv
// usbdev_pkg: shared types and constants for the USB device AON suspend/wake sequencing.
// Rev 1.0
`default_nettype none

package usbdev_pkg;

  typedef enum logic [2:0] {
    AonSeqIdle    = 3'd0,
    AonSeqArm     = 3'd1,
    AonSeqEnter   = 3'd2,
    AonSeqMonitor = 3'd3,
    AonSeqWake    = 3'd4,
    AonSeqRelease = 3'd5,
    AonSeqError   = 3'd6
  } aon_seq_state_e;

  localparam int AonWakeCauseW = 3;

  localparam int AonCauseBusNotIdle = 0;
  localparam int AonCauseBusReset   = 1;
  localparam int AonCauseSenseLost  = 2;

endpackage

`default_nettype wire

// File: rtl/usbdev_aon_suspend_seq.sv
// usbdev_aon_suspend_seq: AON sequencer handing suspend/wake control between usbdev and the wake detector.
// Rev 1.0
`default_nettype none

module usbdev_aon_suspend_seq
  import usbdev_pkg::*;
#(
  parameter int SettleCycles     = 8,
  parameter int HandshakeTimeout = 16
) (
  input  logic                     clk_aon_i,
  input  logic                     rst_aon_ni,
  input  logic                     suspend_req_aon_i,
  input  logic                     wake_ack_aon_i,
  input  logic                     det_active_i,
  input  logic                     det_wake_req_i,
  input  logic                     det_bus_not_idle_i,
  input  logic                     det_bus_reset_i,
  input  logic                     det_sense_lost_i,
  output logic                     det_suspend_req_o,
  output logic                     det_wake_ack_o,
  output logic                     wake_req_aon_o,
  output logic [AonWakeCauseW-1:0] wake_cause_o,
  output logic                     err_o,
  output logic [2:0]               state_o
);

  localparam int CntMax = (SettleCycles > HandshakeTimeout) ? SettleCycles : HandshakeTimeout;
  localparam int CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] SettleLast  = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(HandshakeTimeout - 1);
  localparam logic [CntW-1:0] CntSat      = {CntW{1'b1}};

  aon_seq_state_e state_q, state_d;

  logic [CntW-1:0]          cnt_q;
  logic [AonWakeCauseW-1:0] cause_q;
  logic [AonWakeCauseW-1:0] det_events;
  logic                     err_q;
  logic                     rearm_block_q;
  logic                     counting;
  logic                     arm_edge;
  logic                     capture_cause;

  always_comb begin
    det_events                     = '0;
    det_events[AonCauseBusNotIdle] = det_bus_not_idle_i;
    det_events[AonCauseBusReset]   = det_bus_reset_i;
    det_events[AonCauseSenseLost]  = det_sense_lost_i;
  end

  always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
    if (!rst_aon_ni) begin
      state_q <= AonSeqIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      AonSeqIdle: begin
        if (suspend_req_aon_i && !rearm_block_q) state_d = AonSeqArm;
      end
      AonSeqArm: begin
        if (!suspend_req_aon_i)       state_d = AonSeqIdle;
        else if (cnt_q == SettleLast) state_d = AonSeqEnter;
      end
      AonSeqEnter: begin
        if (det_active_i)              state_d = AonSeqMonitor;
        else if (cnt_q == TimeoutLast) state_d = AonSeqError;
      end
      AonSeqMonitor: begin
        if (det_wake_req_i)      state_d = AonSeqWake;
        else if (wake_ack_aon_i) state_d = AonSeqRelease;
      end
      AonSeqWake: begin
        if (wake_ack_aon_i) state_d = AonSeqRelease;
      end
      AonSeqRelease: begin
        if (!det_active_i)             state_d = AonSeqIdle;
        else if (cnt_q == TimeoutLast) state_d = AonSeqError;
      end
      AonSeqError: begin
        if (!suspend_req_aon_i && !wake_ack_aon_i) state_d = AonSeqIdle;
      end
      default: state_d = AonSeqIdle;
    endcase
  end

  assign counting      = (state_q == AonSeqArm) || (state_q == AonSeqEnter) ||
                         (state_q == AonSeqRelease);
  assign arm_edge      = (state_q == AonSeqIdle) && (state_d == AonSeqArm);
  assign capture_cause = (state_q == AonSeqWake) ||
                         ((state_q == AonSeqMonitor) && (state_d == AonSeqWake));

  // Counter restarts on every state change so each phase times itself from zero.
  always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
    if (!rst_aon_ni) begin
      cnt_q         <= '0;
      cause_q       <= '0;
      err_q         <= 1'b0;
      rearm_block_q <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (counting && (cnt_q != CntSat)) begin
        cnt_q <= cnt_q + CntW'(1);
      end

      if (arm_edge) begin
        cause_q <= '0;
      end else if (capture_cause) begin
        cause_q <= cause_q | det_events;
      end

      if (arm_edge) begin
        err_q <= 1'b0;
      end else if (state_d == AonSeqError) begin
        err_q <= 1'b1;
      end

      // A request still held after handback must be seen low before the next arm.
      if ((state_q == AonSeqRelease) && (state_d == AonSeqIdle)) begin
        rearm_block_q <= suspend_req_aon_i;
      end else if (!suspend_req_aon_i) begin
        rearm_block_q <= 1'b0;
      end
    end
  end

  always_comb begin
    det_suspend_req_o = 1'b0;
    det_wake_ack_o    = 1'b0;
    wake_req_aon_o    = 1'b0;
    unique case (state_q)
      AonSeqEnter:   det_suspend_req_o = 1'b1;
      AonSeqWake:    wake_req_aon_o    = 1'b1;
      AonSeqRelease: det_wake_ack_o    = 1'b1;
      default: ;
    endcase
  end

  assign wake_cause_o = cause_q;
  assign err_o        = err_q;
  assign state_o      = state_q;

endmodule

`default_nettype wire
